ps2_ctrl: RTL and testbench

Sequencing controller for the PS/2 keyboard frame receiver. It consumes completed bytes from the receiver, folds the 0xE0 (extended) and 0xF0 (break) prefixes into single key events, and buffers those events in a small FIFO with a valid/ready handshake toward the host logic. It also runs a stall watchdog on the PS/2 clock line and re-arms the receiver whenever a frame hangs or reports an error.

---
 rtl/ps2_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ps2_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ctrl
// Description : PS/2 keyboard sequencing controller. Folds E0/F0 prefixes
//               into single key events, buffers them in a show-ahead FIFO
//               with a valid/ready interface, and runs a PS/2 clock stall
//               watchdog that re-arms the frame receiver on hang or error.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_ctrl #(
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       rx_done,
   input  logic [7:0] rx_word,
   input  logic       rx_err,
   output logic       rx_rst,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_brk,
   input  logic       ev_ready,
   output logic       timeout,
   output logic       overflow,
   input  logic       ovf_clr
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = $clog2(TIMEOUT_CYCLES);
   // Counter value at which the next increment would reach TIMEOUT_CYCLES-1;
   // firing is registered so the pulse lands exactly TIMEOUT_CYCLES after the edge.
   localparam logic [c_CW-1:0] c_CNT_FIRE = c_CW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GOT_E0   = 2'd1,
      ST_GOT_F0   = 2'd2,
      ST_GOT_E0F0 = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              ps2_prev_q;
   logic              armed_q, armed_d;
   logic [c_CW-1:0]   cnt_q, cnt_d;
   logic              timeout_q, rx_rst_q, overflow_q;
   logic [c_AW:0]     wr_ptr_q, rd_ptr_q;
   logic [9:0]        mem_q [FIFO_DEPTH];

   logic              w_edge, w_fall, w_fire;
   logic              w_emit, w_emit_ext, w_emit_brk;
   logic              w_empty, w_full, w_pop, w_push, w_drop;

   assign w_edge = ps2_clk ^ ps2_prev_q;
   assign w_fall = ps2_prev_q & ~ps2_clk;
   // A completed or failed frame pre-empts the watchdog in its final cycle.
   assign w_fire = armed_q & ~w_edge & ~rx_done & ~rx_err & (cnt_q == c_CNT_FIRE);

   // Watchdog next state: arm on falling edge, clear on any edge, count while armed.
   always_comb begin
      armed_d = armed_q;
      cnt_d   = cnt_q;
      if (rx_done || rx_err || w_fire) begin
         armed_d = 1'b0;
         cnt_d   = '0;
      end else if (w_edge) begin
         cnt_d = '0;
         if (w_fall) armed_d = 1'b1;
      end else if (armed_q) begin
         cnt_d = cnt_q + c_CW'(1);
      end
   end

   // Prefix decoder: error/timeout abandons any pending prefix.
   always_comb begin
      state_d    = state_q;
      w_emit     = 1'b0;
      w_emit_ext = 1'b0;
      w_emit_brk = 1'b0;
      if (rx_err || w_fire) begin
         state_d = ST_IDLE;
      end else if (rx_done) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_word == 8'hE0)      state_d = ST_GOT_E0;
               else if (rx_word == 8'hF0) state_d = ST_GOT_F0;
               else                       w_emit  = 1'b1;
            end
            ST_GOT_E0: begin
               if (rx_word == 8'hF0) begin
                  state_d = ST_GOT_E0F0;
               end else if (rx_word != 8'hE0) begin
                  w_emit     = 1'b1;
                  w_emit_ext = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
            ST_GOT_F0: begin
               w_emit     = 1'b1;
               w_emit_brk = 1'b1;
               state_d    = ST_IDLE;
            end
            default: begin
               w_emit     = 1'b1;
               w_emit_ext = 1'b1;
               w_emit_brk = 1'b1;
               state_d    = ST_IDLE;
            end
         endcase
      end
   end

   // FIFO status; a pop in the same cycle frees a slot for a push into a full FIFO.
   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                    (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
   assign w_pop   = ~w_empty & ev_ready;
   assign w_push  = w_emit & (~w_full | w_pop);
   assign w_drop  = w_emit & w_full & ~w_pop;

   // Control registers: decoder state, watchdog, status pulses and sticky overflow.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ps2_prev_q <= 1'b1;
         armed_q    <= 1'b0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         rx_rst_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ps2_prev_q <= ps2_clk;
         armed_q    <= armed_d;
         cnt_q      <= cnt_d;
         timeout_q  <= w_fire;
         rx_rst_q   <= rx_err | w_fire;
         if (w_drop)       overflow_q <= 1'b1;
         else if (ovf_clr) overflow_q <= 1'b0;
      end
   end

   // Event FIFO storage and pointers; storage is cleared so the head reads zero after reset.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (w_push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= {w_emit_ext, w_emit_brk, rx_word};
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign ev_valid                  = ~w_empty;
   assign {ev_ext, ev_brk, ev_code} = mem_q[rd_ptr_q[c_AW-1:0]];
   assign timeout                   = timeout_q;
   assign rx_rst                    = rx_rst_q;
   assign overflow                  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_ctrl
// Description : Directed self-checking bench for ps2_ctrl (TIMEOUT_CYCLES=8,
//               FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_ctrl;

   logic       sysclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       rx_done = 1'b0;
   logic [7:0] rx_word = 8'h00;
   logic       rx_err = 1'b0;
   logic       rx_rst;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_brk;
   logic       ev_ready = 1'b0;
   logic       timeout;
   logic       overflow;
   logic       ovf_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   ps2_ctrl #(.TIMEOUT_CYCLES(8), .FIFO_DEPTH(4)) dut (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .ps2_clk (ps2_clk),
      .rx_done (rx_done),
      .rx_word (rx_word),
      .rx_err  (rx_err),
      .rx_rst  (rx_rst),
      .ev_valid(ev_valid),
      .ev_code (ev_code),
      .ev_ext  (ev_ext),
      .ev_brk  (ev_brk),
      .ev_ready(ev_ready),
      .timeout (timeout),
      .overflow(overflow),
      .ovf_clr (ovf_clr)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #200000;
      $display("FAIL global_timeout: observed run still active expected finished");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic ext, input logic brk, input logic [7:0] code);
      chk(tag, {21'd0, ev_valid, ev_ext, ev_brk, ev_code}, {21'd0, 1'b1, ext, brk, code});
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   // rx_done is high for the current cycle; returns one cycle later.
   task automatic send_byte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_word = b;
      step();
      rx_done = 1'b0;
   endtask

   task automatic pop_one();
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
   endtask

   initial begin
      int n_to;

      // Reset state
      step();
      step();
      chk("reset_outputs", {25'd0, rx_rst, ev_valid, ev_ext, ev_brk, timeout, overflow, 1'b0},
          32'd0);
      chk("reset_code", {24'd0, ev_code}, 32'd0);
      rst_n = 1'b1;
      step();

      // Make then break
      send_byte(8'h1C);
      chk_head("make_1C", 1'b0, 1'b0, 8'h1C);
      pop_one();
      chk("make_popped", {31'd0, ev_valid}, 32'd0);
      send_byte(8'hF0);
      chk("f0_no_event", {31'd0, ev_valid}, 32'd0);
      send_byte(8'h1C);
      chk_head("break_1C", 1'b0, 1'b1, 8'h1C);
      pop_one();
      chk("break_popped", {31'd0, ev_valid}, 32'd0);

      // Extended release and repeated E0
      send_byte(8'hE0);
      send_byte(8'hF0);
      chk("e0f0_no_event", {31'd0, ev_valid}, 32'd0);
      send_byte(8'h74);
      chk_head("ext_break_74", 1'b1, 1'b1, 8'h74);
      pop_one();
      chk("ext_break_single", {31'd0, ev_valid}, 32'd0);
      send_byte(8'hE0);
      send_byte(8'hE0);
      send_byte(8'h75);
      chk_head("ext_make_75", 1'b1, 1'b0, 8'h75);
      pop_one();
      chk("ext_make_single", {31'd0, ev_valid}, 32'd0);

      // Error mid-prefix
      send_byte(8'hE0);
      rx_err = 1'b1;
      step();
      rx_err = 1'b0;
      chk("err_rx_rst_high", {31'd0, rx_rst}, 32'd1);
      step();
      chk("err_rx_rst_one_cycle", {31'd0, rx_rst}, 32'd0);
      send_byte(8'h1C);
      chk_head("after_err_1C", 1'b0, 1'b0, 8'h1C);
      pop_one();
      chk("after_err_single", {31'd0, ev_valid}, 32'd0);

      // rx_done and rx_err together: byte discarded, receiver reset
      rx_err = 1'b1;
      send_byte(8'h2B);
      rx_err = 1'b0;
      chk("done_err_discard", {30'd0, ev_valid, rx_rst}, 32'd1);

      // Watchdog: single falling edge, line held low
      ps2_clk = 1'b0;
      for (int k = 1; k < 8; k++) begin
         step();
         chk("wd_quiet", {30'd0, timeout, rx_rst}, 32'd0);
      end
      step();
      chk("wd_fire", {30'd0, timeout, rx_rst}, 32'd3);
      step();
      chk("wd_one_cycle", {30'd0, timeout, rx_rst}, 32'd0);

      // Rising edge while disarmed, then edges every 5 cycles
      ps2_clk = 1'b1;
      step();
      n_to = 0;
      for (int i = 0; i < 12; i++) begin
         ps2_clk = ~ps2_clk;
         for (int j = 0; j < 5; j++) begin
            step();
            if (timeout) n_to++;
         end
      end
      chk("wd_edges_no_timeout", n_to, 32'd0);
      // Last edge left the watchdog armed: exactly one timeout follows
      n_to = 0;
      for (int j = 0; j < 12; j++) begin
         step();
         if (timeout) n_to++;
      end
      chk("wd_tail_timeout", n_to, 32'd1);

      // rx_done in the watchdog's final cycle wins
      ps2_clk = 1'b0;
      for (int j = 0; j < 7; j++) step();
      send_byte(8'h2A);
      chk_head("wd_done_wins_event", 1'b0, 1'b0, 8'h2A);
      n_to = (timeout === 1'b1) ? 1 : 0;
      for (int j = 0; j < 10; j++) begin
         step();
         if (timeout) n_to++;
      end
      chk("wd_done_wins_no_timeout", n_to, 32'd0);
      ps2_clk = 1'b1;
      step();
      pop_one();
      chk("wd_done_wins_drained", {31'd0, ev_valid}, 32'd0);

      // Overflow: six codes into a depth-4 FIFO
      for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i));
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk_head("ovf_drain", 1'b0, 1'b0, 8'h11 + 8'(i));
         pop_one();
      end
      chk("ovf_empty", {30'd0, ev_valid, overflow}, 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 32'd0);

      // Full FIFO with simultaneous pop and push
      for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
      chk_head("full_head", 1'b0, 1'b0, 8'h21);
      ev_ready = 1'b1;
      send_byte(8'h25);
      ev_ready = 1'b0;
      chk("full_pop_push_no_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk_head("full_pop_push_drain", 1'b0, 1'b0, 8'h22 + 8'(i));
         pop_one();
      end
      chk("full_pop_push_count4", {31'd0, ev_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
